gray_rx_monitor: RTL and testbench

- Receive-side companion to the 4-bit binary-to-Gray encoder. Sits directly downstream of the encoder output.
- Takes a Gray code that arrives asynchronously to the local clock and passes it through a synchronizer chain.
- Decodes the synchronized code back to binary and reports each legal single-bit step with a direction flag.
- Flags, counts and recovers from illegal multi-bit jumps. These can come from glitches, skew or a broken encoder path.

---
 rtl/gray_rx_monitor_if.sv | 26 ++
 rtl/gray_rx_monitor.sv | 156 +++++++++++++++
 tb/tb_gray_rx_monitor.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/gray_rx_monitor_if.sv
// Bus between the Gray encoder side and gray_rx_monitor: Gray code in, decoded
// position, step pulses and error status out.
`timescale 1ns/1ps
interface gray_rx_monitor_if #(
    parameter int W     = 4,
    parameter int CNT_W = 8
);
    logic [W-1:0]     g_in;
    logic             clr_err;
    logic [W-1:0]     bin_out;
    logic             chg;
    logic             dir;
    logic             step_err;
    logic             err_flag;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output g_in, clr_err,
        input  bin_out, chg, dir, step_err, err_flag, err_cnt
    );

    modport slave (
        input  g_in, clr_err,
        output bin_out, chg, dir, step_err, err_flag, err_cnt
    );
endinterface

// File: rtl/gray_rx_monitor.sv
// Synchronizes an asynchronous Gray code, decodes it to binary, reports legal
// single-bit steps with direction and flags/counts illegal multi-bit jumps.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_INIT  | flushing the synchronizer; loads first code without pulses
//   ST_TRACK | comparing each synchronized code against the last accepted
`timescale 1ns/1ps
module gray_rx_monitor #(
    parameter int W           = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_rx_monitor_if.slave    bus
);

    localparam int IC_W = $clog2(SYNC_STAGES + 1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [IC_W-1:0]  r_init_cnt;
    logic [IC_W-1:0]  w_nxt_init_cnt;
    logic [W-1:0]     r_sync [SYNC_STAGES];
    logic [W-1:0]     r_last_gray;
    logic [W-1:0]     w_nxt_last_gray;
    logic [W-1:0]     r_bin;
    logic [W-1:0]     w_nxt_bin;
    logic             r_chg;
    logic             w_nxt_chg;
    logic             r_dir;
    logic             w_nxt_dir;
    logic             r_step_err;
    logic             w_nxt_step_err;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_err_cnt;

    logic [W-1:0]     w_s_g;
    logic [W-1:0]     w_dec;
    logic [W-1:0]     w_diff;
    logic             w_one_bit;
    logic             w_multi_bit;

    // Plain flop chain: no logic between stages so each bit resolves cleanly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= bus.g_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_s_g = r_sync[SYNC_STAGES-1];

    always_comb begin
        logic w_par;
        w_par = 1'b0;
        w_dec = '0;
        for (int i = W - 1; i >= 0; i--) begin
            w_par    = w_par ^ w_s_g[i];
            w_dec[i] = w_par;
        end
    end

    assign w_diff      = w_s_g ^ r_last_gray;
    assign w_one_bit   = ($countones(w_diff) == 1);
    assign w_multi_bit = ($countones(w_diff) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= '0;
            r_last_gray <= '0;
            r_bin       <= '0;
            r_chg       <= 1'b0;
            r_dir       <= 1'b0;
            r_step_err  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_init_cnt  <= w_nxt_init_cnt;
            r_last_gray <= w_nxt_last_gray;
            r_bin       <= w_nxt_bin;
            r_chg       <= w_nxt_chg;
            r_dir       <= w_nxt_dir;
            r_step_err  <= w_nxt_step_err;
        end
    end

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_init_cnt  = r_init_cnt;
        w_nxt_last_gray = r_last_gray;
        w_nxt_bin       = r_bin;
        w_nxt_chg       = 1'b0;
        w_nxt_dir       = r_dir;
        w_nxt_step_err  = 1'b0;
        case (r_state)
            ST_INIT: begin
                // Load only once s_g holds a code sampled after reset release.
                if (r_init_cnt == IC_W'(SYNC_STAGES)) begin
                    w_nxt_last_gray = w_s_g;
                    w_nxt_bin       = w_dec;
                    w_nxt_init_cnt  = '0;
                    w_nxt_state     = ST_TRACK;
                end else begin
                    w_nxt_init_cnt  = r_init_cnt + IC_W'(1);
                end
            end
            ST_TRACK: begin
                if (w_multi_bit) begin
                    w_nxt_step_err  = 1'b1;
                    w_nxt_last_gray = w_s_g;
                    w_nxt_bin       = w_dec;
                end else if (w_one_bit) begin
                    w_nxt_chg       = 1'b1;
                    w_nxt_last_gray = w_s_g;
                    w_nxt_bin       = w_dec;
                    w_nxt_dir       = (w_dec == (r_bin + W'(1)));
                end
            end
            default: w_nxt_state = ST_INIT;
        endcase
    end

    // A jump detected in the same cycle as clr_err takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end else if (w_nxt_step_err) begin
            r_err_flag <= 1'b1;
            if (bus.clr_err)
                r_err_cnt <= CNT_W'(1);
            else if (r_err_cnt != {CNT_W{1'b1}})
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end else if (bus.clr_err) begin
            r_err_flag <= 1'b0;
            r_err_cnt  <= '0;
        end
    end

    assign bus.bin_out  = r_bin;
    assign bus.chg      = r_chg;
    assign bus.dir      = r_dir;
    assign bus.step_err = r_step_err;
    assign bus.err_flag = r_err_flag;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_gray_rx_monitor.sv
// Bench for gray_rx_monitor: table of Gray steps with a pulse scoreboard, plus
// hand sequences for error saturation, clear priority and mid-run reset.
`timescale 1ns/1ps
module tb_gray_rx_monitor;

    logic clk;
    logic rst_n;

    gray_rx_monitor_if #(.W(4), .CNT_W(8)) bus  ();
    gray_rx_monitor_if #(.W(4), .CNT_W(2)) bus2 ();

    gray_rx_monitor #(.W(4), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    gray_rx_monitor #(.W(4), .SYNC_STAGES(2), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] bin;
        logic       dir;
        logic       chg;
        logic       err;
    } vec_t;

    typedef struct {
        logic [3:0] bin;
        logic       dir;
        logic       chg;
        logic       err;
    } exp_t;

    vec_t tbl [24];
    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [3:0] g_of(int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    function automatic vec_t mk(int b, logic dir, logic chg, logic err);
        vec_t v;
        v.g   = g_of(b);
        v.bin = b[3:0];
        v.dir = dir;
        v.chg = chg;
        v.err = err;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse on dut must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.chg && bus.step_err) check("chg_and_err_together", 1, 0);
            if (bus.chg || bus.step_err) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pulse", {bus.chg, bus.step_err}, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_bin_out",  bus.bin_out,  e.bin);
                    check("sb_chg",      bus.chg,      e.chg);
                    check("sb_step_err", bus.step_err, e.err);
                    check("sb_dir",      bus.dir,      e.dir);
                end
            end
        end
    end

    task automatic push_exp(logic [3:0] bin, logic dir, logic chg, logic err);
        exp_t e;
        e.bin = bin;
        e.dir = dir;
        e.chg = chg;
        e.err = err;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        idx = 0;
        for (int b = 3; b >= 0; b--) begin tbl[idx] = mk(b, 1'b0, 1'b1, 1'b0); idx++; end
        for (int b = 1; b <= 16; b++) begin tbl[idx] = mk(b % 16, 1'b1, 1'b1, 1'b0); idx++; end
        tbl[idx] = mk(15, 1'b0, 1'b1, 1'b0); idx++;
        tbl[idx] = mk(0,  1'b1, 1'b1, 1'b0); idx++;
        tbl[idx] = mk(2,  1'b1, 1'b0, 1'b1); idx++;
        tbl[idx] = mk(3,  1'b1, 1'b1, 1'b0); idx++;

        rst_n        = 1'b0;
        bus.g_in     = 4'b0110;
        bus.clr_err  = 1'b0;
        bus2.g_in    = 4'b0000;
        bus2.clr_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bin_out",  bus.bin_out,  0);
        check("rst_chg",      bus.chg,      0);
        check("rst_step_err", bus.step_err, 0);
        check("rst_err_flag", bus.err_flag, 0);
        check("rst_err_cnt",  bus.err_cnt,  0);

        // INIT: code loads on the third edge after release, silently.
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("init_not_yet_loaded", bus.bin_out, 0);
        @(negedge clk);
        check("init_bin_out",  bus.bin_out,  4);
        check("init_chg",      bus.chg,      0);
        check("init_step_err", bus.step_err, 0);
        check("init_err_cnt",  bus.err_cnt,  0);

        for (int i = 0; i < 24; i++) begin
            bus.g_in = tbl[i].g;
            if (tbl[i].chg || tbl[i].err)
                push_exp(tbl[i].bin, tbl[i].dir, tbl[i].chg, tbl[i].err);
            repeat (3) @(negedge clk);
        end
        wait_drain();
        check("tbl_err_flag", bus.err_flag, 1);
        check("tbl_err_cnt",  bus.err_cnt,  1);

        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
        check("clr_err_flag", bus.err_flag, 0);
        check("clr_err_cnt",  bus.err_cnt,  0);
        check("clr_keeps_bin", bus.bin_out, 3);
        check("clr_keeps_dir", bus.dir,     1);

        // Illegal 3 -> 9 jump, also confirming the SYNC_STAGES+1 edge latency.
        bus.g_in = 4'b1101;
        push_exp(4'd9, 1'b1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("lat_bin_before", bus.bin_out, 3);
        @(negedge clk);
        check("lat_bin_after",  bus.bin_out,  9);
        check("lat_step_err",   bus.step_err, 1);
        wait_drain();
        check("jump9_err_cnt", bus.err_cnt, 1);

        for (int k = 0; k < 5; k++) begin
            bus2.g_in = (k % 2 == 0) ? 4'b0011 : 4'b0000;
            repeat (3) @(negedge clk);
        end
        @(negedge clk);
        check("sat_err_cnt",  bus2.err_cnt,  3);
        check("sat_err_flag", bus2.err_flag, 1);
        bus2.clr_err = 1'b1;
        @(negedge clk);
        bus2.clr_err = 1'b0;
        check("sat_clr_cnt",  bus2.err_cnt,  0);
        check("sat_clr_flag", bus2.err_flag, 0);
        bus2.g_in = 4'b0000;
        repeat (3) @(negedge clk);
        check("one_jump_cnt", bus2.err_cnt, 1);
        bus2.g_in = 4'b0011;
        repeat (2) @(negedge clk);
        bus2.clr_err = 1'b1;
        @(negedge clk);
        bus2.clr_err = 1'b0;
        check("clr_vs_jump_step_err", bus2.step_err, 1);
        check("clr_vs_jump_flag",     bus2.err_flag, 1);
        check("clr_vs_jump_cnt",      bus2.err_cnt,  1);

        // Mid-cycle asynchronous reset with bin_out = 9.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bin",  bus.bin_out,  0);
        check("async_rst_dir",  bus.dir,      0);
        check("async_rst_flag", bus.err_flag, 0);
        check("async_rst_cnt",  bus.err_cnt,  0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rerun_bin", bus.bin_out, 9);
        check("rerun_chg", bus.chg,     0);

        repeat (20) @(negedge clk);
        check("idle_no_pulse_queue", sb_q.size(), 0);
        check("idle_bin", bus.bin_out, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
